// File: rtl/apb_uart_rx_pkg.sv
// Shared definitions for the UART receive register slave:
// register indices, STATUS bit positions, reset values, ingest states.
package apb_uart_rx_pkg;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_COUNT  = 3'd1;
    localparam logic [2:0] REG_BP_LO  = 3'd2;
    localparam logic [2:0] REG_BP_HI  = 3'd3;
    localparam logic [2:0] REG_DSIZE  = 3'd4;
    localparam logic [2:0] REG_IRQ_EN = 3'd5;
    localparam logic [2:0] REG_RXDATA = 3'd6;
    localparam logic [2:0] REG_RSVD   = 3'd7;

    localparam int ST_NE   = 0;
    localparam int ST_FULL = 1;
    localparam int ST_FE   = 2;
    localparam int ST_OE   = 3;

    localparam logic [3:0] DSIZE_RST  = 4'd8;
    localparam int         BP_RST     = 10;
    localparam logic [1:0] IRQ_EN_RST = 2'b00;

    typedef enum logic [1:0] {
        ING_IDLE,
        ING_ACK,
        ING_WAIT
    } ing_state_e;

endpackage

// File: rtl/apb_uart_rx_regs_fifo.sv
// Synchronous receive FIFO with combinational head output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module rx_fifo
    import apb_uart_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata;
        end
    end

endmodule

// File: rtl/apb_uart_rx_regs.sv
// APB3 register slave for the UART receiver: RX FIFO ingest,
// sticky error flags, configuration registers and level interrupt.
module apb_uart_rx_regs
    import apb_uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD_W   = 14
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [7:0]          rx_data,
    input  logic                data_ready,
    input  logic                overrun_error,
    input  logic                framing_error,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [2:0]          paddr,
    input  logic [7:0]          pwdata,
    output logic [7:0]          prdata,
    output logic                pready,
    output logic                pslverr,
    output logic                data_read,
    output logic [3:0]          data_size,
    output logic [PERIOD_W-1:0] bit_period,
    output logic                irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ing_state_e          ing_q;
    logic                data_read_q;
    logic [7:0]          prdata_q, prdata_d;
    logic                pslverr_q, pslverr_d;
    logic [PERIOD_W-1:0] bp_q, bp_d;
    logic [3:0]          dsize_q, dsize_d;
    logic [1:0]          en_q, en_d;
    logic                fe_q, fe_d;
    logic                oe_q, oe_d;
    logic                irq_q, irq_d;
    logic [1:0]          w1c;

    logic                setup, push_req, pop, drop;
    logic                fifo_full, fifo_empty;
    logic [7:0]          head;
    logic [CW-1:0]       count;

    assign setup    = psel & ~penable;
    assign push_req = (ing_q == ING_IDLE) & data_ready;
    assign pop      = setup & ~pwrite & (paddr == REG_RXDATA) & ~fifo_empty;
    // A pop on the same edge frees a slot, so only then is a full push kept.
    assign drop     = push_req & fifo_full & ~pop;

    rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (rx_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_comb begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        bp_d      = bp_q;
        dsize_d   = dsize_q;
        en_d      = en_q;
        w1c       = 2'b00;
        if (setup && pwrite) begin
            case (paddr)
                REG_STATUS: w1c = pwdata[ST_OE:ST_FE];
                REG_BP_LO:  bp_d[7:0] = pwdata;
                REG_BP_HI:  bp_d[PERIOD_W-1:8] = pwdata[PERIOD_W-9:0];
                REG_DSIZE:  dsize_d = pwdata[3:0];
                REG_IRQ_EN: en_d = pwdata[1:0];
                default:    pslverr_d = 1'b1;
            endcase
        end else if (setup) begin
            case (paddr)
                REG_STATUS: prdata_d = {4'b0, oe_q, fe_q, fifo_full, ~fifo_empty};
                REG_COUNT:  prdata_d = 8'(count);
                REG_BP_LO:  prdata_d = bp_q[7:0];
                REG_BP_HI:  prdata_d = 8'(bp_q[PERIOD_W-1:8]);
                REG_DSIZE:  prdata_d = {4'b0, dsize_q};
                REG_IRQ_EN: prdata_d = {6'b0, en_q};
                REG_RXDATA: begin
                    pslverr_d = fifo_empty;
                    prdata_d  = fifo_empty ? 8'h00 : head;
                end
                default:    pslverr_d = 1'b1;
            endcase
        end
        fe_d  = framing_error | (fe_q & ~w1c[0]);
        oe_d  = overrun_error | drop | (oe_q & ~w1c[1]);
        irq_d = (en_q[0] & ~fifo_empty) | (en_q[1] & (fe_q | oe_q));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            bp_q      <= PERIOD_W'(BP_RST);
            dsize_q   <= DSIZE_RST;
            en_q      <= IRQ_EN_RST;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            bp_q      <= bp_d;
            dsize_q   <= dsize_d;
            en_q      <= en_d;
            fe_q      <= fe_d;
            oe_q      <= oe_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ing_q       <= ING_IDLE;
            data_read_q <= 1'b0;
        end else begin
            case (ing_q)
                ING_IDLE: begin
                    if (data_ready) begin
                        ing_q       <= ING_ACK;
                        data_read_q <= 1'b1;
                    end
                end
                ING_ACK: begin
                    ing_q       <= ING_WAIT;
                    data_read_q <= 1'b0;
                end
                ING_WAIT: begin
                    if (!data_ready) begin
                        ing_q <= ING_IDLE;
                    end
                end
                default: begin
                    ing_q       <= ING_IDLE;
                    data_read_q <= 1'b0;
                end
            endcase
        end
    end

    assign prdata     = prdata_q;
    assign pslverr    = pslverr_q;
    assign pready     = 1'b1;
    assign data_read  = data_read_q;
    assign data_size  = dsize_q;
    assign bit_period = bp_q;
    assign irq        = irq_q;

endmodule
